// File: rtl/reg_readback_streamer.sv
// rtl/reg_readback_streamer.sv - address-port owner that streams a wrapping range of register-file entries
module reg_readback_streamer #(
    parameter int WID = 16
) (
    input  logic           wclk,
    input  logic           rst_n,
    input  logic           wce,
    input  logic           we,
    input  logic [4:0]     wadr,
    input  logic [WID-1:0] wdat,
    input  logic           start,
    input  logic [4:0]     first,
    input  logic [5:0]     count,
    input  logic           abort,
    output logic [4:0]     mem_adr,
    output logic           mem_we,
    output logic [WID-1:0] mem_d,
    input  logic [WID-1:0] mem_o,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [WID-1:0] o_data,
    output logic [4:0]     o_adr,
    output logic           o_last,
    output logic           busy,
    output logic           done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  ptr;
    logic [5:0]  remaining;
    logic [5:0]  count_cl;
    logic        host_wr;
    logic        xfer;
    logic        slot_free;
    logic        issue;
    logic        fwd;
    logic        start_go;
    logic        abort_run;
    logic        finish;

    // Host writes own the shared address port; reads use it only on idle write cycles.
    assign host_wr = wce & we;
    assign mem_we  = host_wr;
    assign mem_d   = wdat;
    assign mem_adr = host_wr ? wadr : ptr;

    // A zero count means a full sweep; anything beyond the file depth is a full sweep too.
    assign count_cl  = ((count == 6'd0) || (count > 6'd32)) ? 6'd32 : count;

    assign xfer      = o_valid & o_ready;
    assign slot_free = ~o_valid | o_ready;
    assign abort_run = (state == RUN) & abort;
    assign start_go  = (state == IDLE) & start & ~abort;
    assign finish    = (state == RUN) & xfer & o_last;
    assign issue     = (state == RUN) & ~abort & ~host_wr & (remaining != 6'd0) & slot_free;
    // A stalled beat picks up a host write to its own address so the dump never shows stale data.
    assign fwd       = host_wr & o_valid & ~o_ready & (wadr == o_adr);

    // State register.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: abort beats completion, completion returns to idle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_go) state_nxt = RUN;
            RUN:  if (abort_run || finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = 1'b0;
        if (state == RUN) busy = 1'b1;
    end

    // Read pointer, beat counter and the single output slot.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 5'd0;
            remaining <= 6'd0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_adr     <= 5'd0;
            o_last    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_run) begin
                o_valid   <= 1'b0;
                o_last    <= 1'b0;
                remaining <= 6'd0;
            end else if (start_go) begin
                ptr       <= first;
                remaining <= count_cl;
            end else if (state == RUN) begin
                if (issue) begin
                    o_data    <= mem_o;
                    o_adr     <= ptr;
                    o_valid   <= 1'b1;
                    o_last    <= (remaining == 6'd1);
                    ptr       <= ptr + 5'd1;
                    remaining <= remaining - 6'd1;
                end else if (xfer) begin
                    o_valid <= 1'b0;
                    if (o_last) begin
                        o_last <= 1'b0;
                        done   <= 1'b1;
                    end
                end else if (fwd) begin
                    o_data <= wdat;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_readback_streamer.sv
// tb/tb_reg_readback_streamer.sv - directed bench for reg_readback_streamer
module tb_reg_readback_streamer;

    localparam int WID = 16;

    logic           wclk = 1'b0;
    logic           rst_n;
    logic           wce;
    logic           we;
    logic [4:0]     wadr;
    logic [WID-1:0] wdat;
    logic           start;
    logic [4:0]     first;
    logic [5:0]     count;
    logic           abort;
    logic [4:0]     mem_adr;
    logic           mem_we;
    logic [WID-1:0] mem_d;
    logic [WID-1:0] mem_o;
    logic           o_valid;
    logic           o_ready;
    logic [WID-1:0] o_data;
    logic [4:0]     o_adr;
    logic           o_last;
    logic           busy;
    logic           done;

    int checks   = 0;
    int failures = 0;

    logic [WID-1:0] ram      [32];
    logic [WID-1:0] exp_regs [32];

    logic [4:0]     q_adr  [$];
    logic [WID-1:0] q_data [$];
    logic           q_last [$];

    int   nc;
    int   hb;
    logic sd;

    reg_readback_streamer #(.WID(WID)) dut (
        .wclk    (wclk),
        .rst_n   (rst_n),
        .wce     (wce),
        .we      (we),
        .wadr    (wadr),
        .wdat    (wdat),
        .start   (start),
        .first   (first),
        .count   (count),
        .abort   (abort),
        .mem_adr (mem_adr),
        .mem_we  (mem_we),
        .mem_d   (mem_d),
        .mem_o   (mem_o),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_adr   (o_adr),
        .o_last  (o_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) begin
        if (mem_we) ram[mem_adr] <= mem_d;
    end
    assign mem_o = ram[mem_adr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [5:0] n);
        start = 1'b1;
        first = f;
        count = n;
        @(negedge wclk);
        start = 1'b0;
    endtask

    task automatic collect(input int budget, input logic [63:0] rdy_n_mask,
                           input logic [63:0] wr_mask, output int ncyc,
                           output int hold_bad, output logic saw_done);
        logic       pv;
        logic       pr;
        logic [4:0] pa;
        q_adr.delete();
        q_data.delete();
        q_last.delete();
        pv = 1'b0;
        pr = 1'b1;
        pa = 5'd0;
        hold_bad = 0;
        saw_done = 1'b0;
        ncyc = budget;
        for (int c = 0; c < budget; c++) begin
            if (done === 1'b1) begin
                saw_done = 1'b1;
                ncyc = c;
                break;
            end
            o_ready = (c < 64) ? ~rdy_n_mask[c[5:0]] : 1'b1;
            wce     = (c < 64) ? wr_mask[c[5:0]] : 1'b0;
            we      = wce;
            if (pv && !pr && !(o_valid === 1'b1 && o_adr == pa)) hold_bad++;
            if (o_valid === 1'b1 && o_ready) begin
                q_adr.push_back(o_adr);
                q_data.push_back(o_data);
                q_last.push_back(o_last);
            end
            pv = o_valid;
            pr = o_ready;
            pa = o_adr;
            @(negedge wclk);
        end
        wce = 1'b0;
        we = 1'b0;
        o_ready = 1'b1;
    endtask

    function automatic int seq_bad(input logic [4:0] f, input int n);
        int bad = 0;
        logic [4:0] a;
        for (int i = 0; i < n && i < q_adr.size(); i++) begin
            a = f + i[4:0];
            if (q_adr[i] !== a || q_data[i] !== exp_regs[a]) bad++;
        end
        return bad;
    endfunction

    function automatic int last_bad();
        int bad = 0;
        for (int i = 0; i < q_last.size(); i++) begin
            if (q_last[i] !== (i == q_last.size() - 1)) bad++;
        end
        return bad;
    endfunction

    initial begin
        rst_n = 1'b0; wce = 1'b0; we = 1'b0; wadr = 5'd0; wdat = '0;
        start = 1'b0; first = 5'd0; count = 6'd0; abort = 1'b0; o_ready = 1'b1;
        repeat (2) @(negedge wclk);
        chk("rst o_valid", o_valid, 0);
        chk("rst o_data", o_data, 0);
        chk("rst o_adr", o_adr, 0);
        chk("rst o_last", o_last, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 32; k++) begin
            wce = 1'b1; we = 1'b1; wadr = k[4:0]; wdat = WID'(k * 3);
            exp_regs[k] = WID'(k * 3);
            if (k == 5) begin
                #1;
                chk("pre mem_adr", mem_adr, 5);
                chk("pre mem_we", mem_we, 1);
                chk("pre mem_d", mem_d, 15);
            end
            @(negedge wclk);
        end
        wce = 1'b0; we = 1'b0;
        chk("pre busy", busy, 0);

        // basic dump 0..3, cycle-exact
        start_dump(5'd0, 6'd4);
        chk("t1 busy", busy, 1);
        chk("t1 no beat yet", o_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge wclk);
            chk("t1 valid", o_valid, 1);
            chk("t1 adr", o_adr, k);
            chk("t1 data", o_data, k * 3);
            chk("t1 last", o_last, (k == 3) ? 1 : 0);
            chk("t1 no done", done, 0);
        end
        @(negedge wclk);
        chk("t1 done", done, 1);
        chk("t1 valid off", o_valid, 0);
        chk("t1 idle", busy, 0);
        @(negedge wclk);
        chk("t1 done pulse", done, 0);

        // wrap 30,31,0,1
        start_dump(5'd30, 6'd4);
        collect(40, 64'h0, 64'h0, nc, hb, sd);
        chk("t2 done", sd, 1);
        chk("t2 beats", q_adr.size(), 4);
        chk("t2 seq", seq_bad(5'd30, 4), 0);
        chk("t2 last", last_bad(), 0);
        chk("t2 cycles", nc, 5);

        // count=0 means 32
        start_dump(5'd7, 6'd0);
        collect(80, 64'h0, 64'h0, nc, hb, sd);
        chk("t3 beats", q_adr.size(), 32);
        chk("t3 seq", seq_bad(5'd7, 32), 0);
        chk("t3 last", last_bad(), 0);
        chk("t3 cycles", nc, 33);

        // count>32 clamps to 32
        start_dump(5'd0, 6'd40);
        collect(80, 64'h0, 64'h0, nc, hb, sd);
        chk("t3b beats", q_adr.size(), 32);
        chk("t3b seq", seq_bad(5'd0, 32), 0);

        // sink stall for 3 cycles
        start_dump(5'd12, 6'd6);
        collect(40, 64'h1C, 64'h0, nc, hb, sd);
        chk("t4 beats", q_adr.size(), 6);
        chk("t4 seq", seq_bad(5'd12, 6), 0);
        chk("t4 hold", hb, 0);
        chk("t4 cycles", nc, 10);

        // host writes every other cycle stall issue
        wadr = 5'd5; wdat = 16'hBEEF;
        exp_regs[5] = 16'hBEEF;
        start_dump(5'd0, 6'd8);
        collect(60, 64'h0, 64'h5555555555555555, nc, hb, sd);
        chk("t5 beats", q_adr.size(), 8);
        chk("t5 seq", seq_bad(5'd0, 8), 0);
        chk("t5 cycles", nc, 17);

        // forwarding into a stalled beat
        start_dump(5'd4, 6'd3);
        o_ready = 1'b0;
        @(negedge wclk);
        chk("t5b adr4", o_adr, 4);
        chk("t5b data4", o_data, 12);
        o_ready = 1'b1;
        @(negedge wclk);
        chk("t5b adr5", o_adr, 5);
        chk("t5b data5", o_data, 16'hBEEF);
        o_ready = 1'b0;
        wce = 1'b1; we = 1'b1; wadr = 5'd5; wdat = 16'h1234;
        #1;
        chk("t5b mem_adr", mem_adr, 5);
        chk("t5b mem_we", mem_we, 1);
        @(negedge wclk);
        wce = 1'b0; we = 1'b0;
        exp_regs[5] = 16'h1234;
        chk("t5b held adr", o_adr, 5);
        chk("t5b fwd data", o_data, 16'h1234);
        chk("t5b held valid", o_valid, 1);
        o_ready = 1'b1;
        @(negedge wclk);
        chk("t5b adr6", o_adr, 6);
        chk("t5b data6", o_data, 18);
        chk("t5b last6", o_last, 1);
        @(negedge wclk);
        chk("t5b done", done, 1);

        // abort after two beats, then a fresh dump
        start_dump(5'd0, 6'd8);
        repeat (3) @(negedge wclk);
        chk("t6 pre adr", o_adr, 2);
        abort = 1'b1;
        @(negedge wclk);
        abort = 1'b0;
        chk("t6 valid off", o_valid, 0);
        chk("t6 idle", busy, 0);
        chk("t6 no done", done, 0);
        @(negedge wclk);
        chk("t6 no done2", done, 0);
        start_dump(5'd10, 6'd2);
        collect(40, 64'h0, 64'h0, nc, hb, sd);
        chk("t6 done", sd, 1);
        chk("t6 beats", q_adr.size(), 2);
        chk("t6 seq", seq_bad(5'd10, 2), 0);
        chk("t6 cycles", nc, 3);

        // start while busy is ignored
        start_dump(5'd20, 6'd5);
        chk("t7 busy", busy, 1);
        start = 1'b1; first = 5'd9; count = 6'd1;
        @(negedge wclk);
        start = 1'b0;
        collect(40, 64'h0, 64'h0, nc, hb, sd);
        chk("t7 beats", q_adr.size(), 5);
        chk("t7 seq", seq_bad(5'd20, 5), 0);
        chk("t7 last", last_bad(), 0);

        // async reset mid-dump
        start_dump(5'd3, 6'd8);
        o_ready = 1'b0;
        repeat (3) @(negedge wclk);
        chk("t8 pending", o_valid, 1);
        chk("t8 pending adr", o_adr, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t8 o_valid", o_valid, 0);
        chk("t8 o_data", o_data, 0);
        chk("t8 o_adr", o_adr, 0);
        chk("t8 o_last", o_last, 0);
        chk("t8 busy", busy, 0);
        @(negedge wclk);
        rst_n = 1'b1;
        o_ready = 1'b1;
        start_dump(5'd31, 6'd1);
        collect(20, 64'h0, 64'h0, nc, hb, sd);
        chk("t8 beats", q_adr.size(), 1);
        chk("t8 seq", seq_bad(5'd31, 1), 0);
        chk("t8 last", last_bad(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_readback_streamer.md
Name: reg_readback_streamer

Overview:
Sequential reader for a 32-entry distributed-RAM register file (RAM32X1S-per-bit, async read, single shared address port). It owns the address port, gives host writes priority, and on request streams a contiguous, wrapping range of entries out over a valid/ready interface. It is used for debug dumps, context save, and scrubbing of register memories.

Parameters:
WID, 16, data width of the register file and the stream.

Ports:
wclk  in  1  sole clock; all state is rising-edge.
rst_n  in  1  asynchronous active-low reset.
wce  in  1  host write cycle enable.
we  in  1  host write enable; a host write occurs when wce&we.
wadr  in  5  host write address.
wdat  in  WID  host write data.
start  in  1  dump request pulse.
first  in  5  first address of the dump.
count  in  6  number of entries; 0 is treated as 32, and values >32 are clamped to 32.
abort  in  1  cancels the dump.
mem_adr  out  5  register memory address.
mem_we  out  1  register memory write enable.
mem_d  out  WID  register memory write data.
mem_o  in  WID  register memory async read data.
o_valid  out  1  stream data valid.
o_ready  in  1  stream sink ready.
o_data  out  WID  stream data.
o_adr  out  5  address of o_data.
o_last  out  1  final beat of the dump.
busy  out  1  dump in progress.
done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - o_valid=0, o_data=0, o_adr=0, o_last=0, busy=0, done=0.
  - ptr=0, remaining=0.
- Memory port (combinational):
  - mem_we = wce&we.
  - mem_d = wdat.
  - mem_adr = (wce&we) ? wadr : ptr.
- Host writes are never stalled or dropped, in any state.
- States:
  - IDLE: busy=0. On start: ptr<=first, remaining<=clamped count, go to RUN.
  - RUN: busy=1.
- start in RUN is ignored.
- Issue rule in RUN: a read issues in a cycle when all of the following hold:
  - no host write this cycle;
  - remaining != 0;
  - the output slot is free (o_valid=0, or o_valid&o_ready).
- On issue, at the clock edge:
  - o_data<=mem_o, o_adr<=ptr, o_valid<=1;
  - o_last<=(remaining==1);
  - ptr<=ptr+1 (mod 32, so 31 wraps to 0);
  - remaining<=remaining-1.
- Latency: 1 cycle from issue to o_valid. Full throughput is 1 beat per cycle while o_ready=1 and there are no host writes.
- Output handshake:
  - A beat transfers when o_valid&o_ready.
  - o_data, o_adr and o_last are held stable while o_valid&!o_ready, except for write forwarding (below).
  - If the slot is accepted with no new issue, o_valid<=0.
- Write forwarding: if a host write hits o_adr while o_valid=1 and the beat is not transferring, o_data<=wdat. The stream therefore always carries the current register value.
- Completion: when the beat with o_last=1 transfers:
  - done=1 for one cycle;
  - state returns to IDLE;
  - o_valid<=0, o_last<=0.
- Abort:
  - abort in RUN clears o_valid and o_last, returns to IDLE, and sets remaining<=0. No done pulse.
  - abort in IDLE has no effect.
  - abort has priority over start and over issue in the same cycle.
- Entries not yet read naturally reflect any intervening host write. Entries already transferred are not re-sent.

Test Plan:
- Preload regs k=k*3. start, first=0, count=4, o_ready=1 -> beats (adr,data) (0,0)(1,3)(2,6)(3,9) on consecutive cycles; o_last only on adr 3; done one cycle after.
- first=30, count=4 -> adr sequence 30,31,0,1 (wrap); count=0 -> 32 beats starting at first.
- o_ready=0 for 3 cycles mid-dump -> o_data/o_adr held; no beat lost or duplicated; remaining beats resume in order.
- Host write adr=5 data=0xBEEF every other cycle during a dump of 0..7 -> issue stalls on write cycles; beat adr=5 carries 0xBEEF; if it is already pending with o_ready=0, o_data updates to 0xBEEF.
- abort after 2 beats, then start first=10, count=2 -> o_valid drops the next cycle, no done pulse; new dump yields adr 10,11 and done.
- rst_n low mid-dump -> all outputs 0 immediately (async); start during busy -> ignored, current dump unaffected.
